// File: rtl/saes_pkg.sv
// saes_pkg: shared widths, FSM encoding and datapath helpers for the simplified-AES engine.
package saes_pkg;
   localparam int BLOCK_W = 64;
   localparam int NIBBLE_W = 4;
   localparam int NIBBLES = 16;
   localparam int DEFAULT_ROUNDS = 10;
   // Entry n lives in bits [4n+3:4n]; 0->6->F->9->2->0 is one of its cycles.
   localparam logic [BLOCK_W-1:0] SBOX_TABLE = 64'h94A5_732E_CF81_D0B6;
   typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} stateT;
   function automatic logic [BLOCK_W-1:0] key_step(input logic [BLOCK_W-1:0] k);
      return {k[59:0], k[63:60]};
   endfunction
   function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
      return {s[51:48], s[63:52], s[39:32], s[47:40], s[27:16], s[31:28], s[15:0]};
   endfunction
endpackage

// File: rtl/saes_round_step.sv
// saes_round_step: one combinational cipher round, ShiftRows(SubNibbles(s)) ^ k.
module saes_round_step
   import saes_pkg::*;
(
   input  logic [BLOCK_W-1:0] stateIn,
   input  logic [BLOCK_W-1:0] keyIn,
   output logic [BLOCK_W-1:0] stateOut
);
   logic [BLOCK_W-1:0] subbed;
   for (genvar i = 0; i < NIBBLES; i++) begin : gSbox
      assign subbed[i*NIBBLE_W +: NIBBLE_W] = SBOX_TABLE[{stateIn[i*NIBBLE_W +: NIBBLE_W], 2'b00} +: NIBBLE_W];
   end
   assign stateOut = shift_rows(subbed) ^ keyIn;
endmodule

// File: rtl/saes_iter_engine.sv
// saes_iter_engine: iterative simplified-AES encryptor, one round per cycle over a shared round step,
// with valid/ready handshakes on both sides and back-to-back acceptance from DONE.
module saes_iter_engine
   import saes_pkg::*;
#(
   parameter int NUM_ROUNDS = DEFAULT_ROUNDS,
   localparam int CNT_W = 4
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BLOCK_W-1:0] in_plaintext,
   input  logic [BLOCK_W-1:0] in_key,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] out_ciphertext,
   output logic               busy,
   output logic [CNT_W-1:0]   round_idx
);
   if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : gBadRounds
      $error("saes_iter_engine: NUM_ROUNDS must be within 1..15");
   end
   stateT state;
   logic [BLOCK_W-1:0] stateReg, keyReg, nextKey, roundOut;
   logic [CNT_W-1:0] cnt;
   logic accept;
   assign nextKey = key_step(keyReg);
   saes_round_step uStep (
      .stateIn (stateReg),
      .keyIn   (nextKey),
      .stateOut(roundOut)
   );
   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign accept = in_valid && in_ready;
   assign out_valid = state == DONE;
   assign busy = state == ROUND;
   assign round_idx = busy ? cnt : '0;
   assign out_ciphertext = out_valid ? stateReg : '0;
   // A DONE handshake with a new block pending goes through the accept branch, skipping IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         stateReg <= '0;
         keyReg <= '0;
         cnt <= '0;
      end else if (flush) begin
         state <= IDLE;
         cnt <= '0;
      end else if (accept) begin
         state <= ROUND;
         stateReg <= in_plaintext ^ in_key;
         keyReg <= in_key;
         cnt <= CNT_W'(1);
      end else if (state == ROUND) begin
         stateReg <= roundOut;
         keyReg <= nextKey;
         cnt <= cnt + CNT_W'(1);
         if (cnt == CNT_W'(NUM_ROUNDS)) state <= DONE;
      end else if (state == DONE && out_ready) begin
         state <= IDLE;
         cnt <= '0;
      end
   end
endmodule

// File: tb/tb_saes_iter_engine.sv
// tb_saes_iter_engine: directed and random checks of the iterative engine against an unrolled reference.
module tb_saes_iter_engine;
   localparam int NR = 10;
   localparam logic [3:0] SB [16] = '{4'h6, 4'hB, 4'h0, 4'hD, 4'h1, 4'h8, 4'hF, 4'hC,
                                      4'hE, 4'h2, 4'h3, 4'h7, 4'h5, 4'hA, 4'h4, 4'h9};
   logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [63:0] in_plaintext = '0, in_key = '0;
   logic in_ready, out_valid, busy;
   logic [63:0] out_ciphertext;
   logic [3:0] round_idx;
   logic shortValid = 1'b0, shortReady = 1'b1;
   logic [63:0] zero64 = '0;
   logic ir3, ov3, bz3, ir1, ov1, bz1;
   logic [63:0] ct3, ct1;
   logic [3:0] ri3, ri1;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   saes_iter_engine #(.NUM_ROUNDS(NR)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_plaintext(in_plaintext), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
      .out_ciphertext(out_ciphertext), .busy(busy), .round_idx(round_idx));
   saes_iter_engine #(.NUM_ROUNDS(3)) dut3 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(shortValid), .in_ready(ir3),
      .in_plaintext(zero64), .in_key(zero64), .out_valid(ov3), .out_ready(shortReady),
      .out_ciphertext(ct3), .busy(bz3), .round_idx(ri3));
   saes_iter_engine #(.NUM_ROUNDS(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(shortValid), .in_ready(ir1),
      .in_plaintext(zero64), .in_key(zero64), .out_valid(ov1), .out_ready(shortReady),
      .out_ciphertext(ct1), .busy(bz1), .round_idx(ri1));

   // Unrolled encryptor: rows of four nibbles, row r rotated left by r nibbles.
   function automatic logic [63:0] model(input logic [63:0] pt, input logic [63:0] key, input int nr);
      logic [63:0] s, k, t;
      logic [15:0] row;
      s = pt ^ key;
      k = key;
      for (int i = 0; i < nr; i++) begin
         k = (k << 4) | (k >> 60);
         for (int n = 0; n < 16; n++) t[n*4 +: 4] = SB[s[n*4 +: 4]];
         for (int r = 0; r < 4; r++) begin
            row = t[r*16 +: 16];
            s[r*16 +: 16] = 16'((32'(row) << (4*r)) | (32'(row) >> (16 - 4*r)));
         end
         s = s ^ k;
      end
      return s;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic waitOut(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // Called at a negedge with the engine idle; holds the result for `stall` cycles before taking it.
   task automatic runBlock(input logic [63:0] pt, input logic [63:0] key, input logic [63:0] exp,
                           input int stall, input string tag);
      int cyc;
      in_plaintext = pt;
      in_key = key;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_plaintext = ~pt;
      in_key = {$urandom, $urandom};
      waitOut(cyc);
      check({tag, " latency"}, 64'(cyc), 64'(NR));
      for (int i = 0; i < stall; i++) begin
         check({tag, " held valid"}, 64'(out_valid), 64'd1);
         check({tag, " held ct"}, out_ciphertext, exp);
         @(negedge clk);
      end
      out_ready = 1'b1;
      check({tag, " ct"}, out_ciphertext, exp);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " retired"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      int cyc;
      logic saw;
      logic [63:0] a, b, ka, kb;
      repeat (2) @(negedge clk);
      check("reset in_ready", 64'(in_ready), 64'd1);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset round_idx", 64'(round_idx), 64'd0);
      check("reset ct", out_ciphertext, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      // Short configurations
      shortValid = 1'b1;
      @(negedge clk);
      shortValid = 1'b0;
      check("short3 n1 valid", 64'(ov3), 64'd0);
      check("short1 n1 valid", 64'(ov1), 64'd0);
      @(negedge clk);
      check("short1 valid", 64'(ov1), 64'd1);
      check("short1 ct", ct1, 64'h6666_6666_6666_6666);
      check("short3 n2 valid", 64'(ov3), 64'd0);
      @(negedge clk);
      check("short3 n3 valid", 64'(ov3), 64'd0);
      @(negedge clk);
      check("short3 valid", 64'(ov3), 64'd1);
      check("short3 ct", ct3, 64'h9999_9999_9999_9999);
      @(negedge clk);
      // Zero vector with round index walk
      in_plaintext = '0;
      in_key = '0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1 check("zero in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      for (int r = 1; r <= NR; r++) begin
         check("zero in_ready low", 64'(in_ready), 64'd0);
         check("zero busy", 64'(busy), 64'd1);
         check("zero round_idx", 64'(round_idx), 64'(r));
         @(negedge clk);
      end
      check("zero valid", 64'(out_valid), 64'd1);
      check("zero ct", out_ciphertext, 64'd0);
      check("zero in_ready pass", 64'(in_ready), 64'd1);
      out_ready = 1'b0;
      #1 check("zero in_ready follows", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      @(negedge clk);
      check("zero retired", 64'(out_valid), 64'd0);
      out_ready = 1'b0;
      // Uniform key with long backpressure
      runBlock(64'h6666_6666_6666_6666, 64'h6666_6666_6666_6666, 64'd0, 20, "uniform");
      // Back-to-back
      a = {$urandom, $urandom}; ka = {$urandom, $urandom};
      b = {$urandom, $urandom}; kb = {$urandom, $urandom};
      in_plaintext = a; in_key = ka; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      waitOut(cyc);
      check("b2b first latency", 64'(cyc), 64'(NR));
      in_plaintext = b; in_key = kb; in_valid = 1'b1; out_ready = 1'b1;
      #1 check("b2b in_ready", 64'(in_ready), 64'd1);
      check("b2b ct a", out_ciphertext, model(a, ka, NR));
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      check("b2b no idle busy", 64'(busy), 64'd1);
      check("b2b round 1", 64'(round_idx), 64'd1);
      waitOut(cyc);
      check("b2b period", 64'(cyc), 64'(NR));
      check("b2b ct b", out_ciphertext, model(b, kb, NR));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      // Flush mid-round
      in_plaintext = {$urandom, $urandom}; in_key = {$urandom, $urandom}; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("flush at round 5", 64'(round_idx), 64'd5);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", 64'(busy), 64'd0);
      check("flush round_idx", 64'(round_idx), 64'd0);
      check("flush in_ready", 64'(in_ready), 64'd1);
      saw = 1'b0;
      repeat (15) begin
         saw |= out_valid;
         @(negedge clk);
      end
      check("flush no output", 64'(saw), 64'd0);
      a = {$urandom, $urandom}; ka = {$urandom, $urandom};
      runBlock(a, ka, model(a, ka, NR), 1, "after flush");
      // Flush beats in_valid in IDLE
      flush = 1'b1; in_valid = 1'b1; in_plaintext = {$urandom, $urandom};
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check("flushprio busy", 64'(busy), 64'd0);
      check("flushprio round_idx", 64'(round_idx), 64'd0);
      saw = 1'b0;
      repeat (15) begin
         saw |= out_valid | busy;
         @(negedge clk);
      end
      check("flushprio stays idle", 64'(saw), 64'd0);
      // Asynchronous reset mid-round
      in_plaintext = {$urandom, $urandom}; in_key = {$urandom, $urandom}; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("arst pre busy", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1 check("arst in_ready", 64'(in_ready), 64'd1);
      check("arst busy", 64'(busy), 64'd0);
      check("arst round_idx", 64'(round_idx), 64'd0);
      check("arst out_valid", 64'(out_valid), 64'd0);
      check("arst ct", out_ciphertext, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      a = {$urandom, $urandom}; ka = {$urandom, $urandom};
      runBlock(a, ka, model(a, ka, NR), 2, "after reset");
      // Random blocks with random stalls
      for (int i = 0; i < 1000; i++) begin
         a = {$urandom, $urandom}; ka = {$urandom, $urandom};
         runBlock(a, ka, model(a, ka, NR), int'($urandom_range(0, 3)), "random");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
